// File: rtl/xbar_param.sv
// xbar_param: NPORT x NPORT crossbar with one-hot per-output source select,
// multicast, and a one-entry registered output stage per port.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   in_data    input flits, port i at [i*DW +: DW]
//   in_valid   per-input flit valid
//   in_ready   per-input accept (combinational, independent of in_valid)
//   sel        per-output one-hot source select, output o at [o*NPORT +: NPORT]
//   out_data   registered output flits, port o at [o*DW +: DW]
//   out_valid  per-output register occupied
//   out_ready  per-output downstream accept
//   err_cnt    saturating count of cycles with a multi-hot select whose
//              selected inputs carry a valid flit
//
// Build option: define XBAR_PARAM_ERRCNT_EN to enable the err_cnt counter;
// otherwise err_cnt is tied to zero.
module xbar_param #(
    parameter int NPORT = 3,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT*DW-1:0]    in_data,
    input  logic [NPORT-1:0]       in_valid,
    output logic [NPORT-1:0]       in_ready,
    input  logic [NPORT*NPORT-1:0] sel,
    output logic [NPORT*DW-1:0]    out_data,
    output logic [NPORT-1:0]       out_valid,
    input  logic [NPORT-1:0]       out_ready,
    output logic [7:0]             err_cnt
);
    logic [NPORT*NPORT-1:0] w_lsel;
    logic [NPORT-1:0]       w_can_load;
    logic [NPORT-1:0]       w_used;
    logic [NPORT-1:0]       w_block;
    logic [NPORT-1:0]       w_load;
    logic [NPORT*DW-1:0]    w_next_data;
    logic [NPORT*DW-1:0]    r_data;
    logic [NPORT-1:0]       r_valid;

    // Idle and multi-hot selects are masked to zero so they neither load nor
    // take part in the acceptance decision.
    always_comb begin
        w_lsel     = '0;
        w_can_load = '0;
        for (int o = 0; o < NPORT; o++) begin
            w_lsel[o*NPORT +: NPORT] = $onehot(sel[o*NPORT +: NPORT]) ? sel[o*NPORT +: NPORT] : '0;
            w_can_load[o]            = !r_valid[o] || out_ready[o];
        end
    end

    // An input is accepted only if it has at least one legal destination and
    // none of those destinations is stalled; this keeps multicast atomic.
    always_comb begin
        w_used  = '0;
        w_block = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (w_lsel[o*NPORT + i]) begin
                    w_used[i] = 1'b1;
                    if (!w_can_load[o])
                        w_block[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = rst ? (w_used & ~w_block) : '0;

    always_comb begin
        w_load      = '0;
        w_next_data = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (w_lsel[o*NPORT + i] && in_valid[i] && in_ready[i]) begin
                    w_load[o]                = 1'b1;
                    w_next_data[o*DW +: DW]  = in_data[i*DW +: DW];
                end
            end
        end
    end

    // Load has priority over drain so a simultaneous drain+load keeps full rate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (w_load[o]) begin
                    r_valid[o]         <= 1'b1;
                    r_data[o*DW +: DW] <= w_next_data[o*DW +: DW];
                end else if (out_ready[o]) begin
                    r_valid[o] <= 1'b0;
                end
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;

`ifdef XBAR_PARAM_ERRCNT_EN
    logic       w_err;
    logic [7:0] r_err_cnt;

    // One increment per cycle no matter how many outputs are misconfigured.
    always_comb begin
        w_err = 1'b0;
        for (int o = 0; o < NPORT; o++) begin
            if (!$onehot0(sel[o*NPORT +: NPORT]) && |(sel[o*NPORT +: NPORT] & in_valid))
                w_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_err_cnt <= 8'd0;
        else if (w_err && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_xbar_param.sv
// tb_xbar_param: scoreboard bench for xbar_param (NPORT=3, DW=8).
module tb_xbar_param;
    localparam int NP = 3;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*DW-1:0]  in_data;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [NP*NP-1:0]  sel;
    logic [NP*DW-1:0]  out_data;
    logic [NP-1:0]     out_valid;
    logic [NP-1:0]     out_ready;
    logic [7:0]        err_cnt;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] mdl_err = 8'd0;
    logic [DW-1:0] exp_q [NP][$];

    xbar_param #(.NPORT(NP), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_err();
`ifdef XBAR_PARAM_ERRCNT_EN
        return mdl_err;
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic [NP-1:0] mdl_ready();
        logic [NP-1:0] r;
        logic [NP-1:0] s;
        logic used, blk;
        r = '0;
        for (int i = 0; i < NP; i++) begin
            used = 1'b0;
            blk  = 1'b0;
            for (int o = 0; o < NP; o++) begin
                s = sel[o*NP +: NP];
                if ($countones(s) == 1 && s[i]) begin
                    used = 1'b1;
                    if (exp_q[o].size() != 0 && !out_ready[o]) blk = 1'b1;
                end
            end
            r[i] = used && !blk;
        end
        return r;
    endfunction

    task automatic drive(input logic [NP*NP-1:0] s, input logic [NP*DW-1:0] d,
                         input logic [NP-1:0] v, input logic [NP-1:0] r);
        sel = s; in_data = d; in_valid = v; out_ready = r;
    endtask

    // Called on a negedge with inputs set; checks, updates the scoreboard and
    // returns on the following negedge.
    task automatic step();
        logic [NP-1:0] rdy;
        logic [NP-1:0] s;
        logic hit;
        #1;
        rdy = mdl_ready();
        check("in_ready", in_ready, rdy);
        check("err_cnt", err_cnt, exp_err());
        for (int o = 0; o < NP; o++) begin
            check($sformatf("out_valid%0d", o), out_valid[o], exp_q[o].size() != 0);
            if (exp_q[o].size() != 0 && out_ready[o])
                check($sformatf("out_data%0d", o), out_data[o*DW +: DW], exp_q[o].pop_front());
        end
        hit = 1'b0;
        for (int o = 0; o < NP; o++) begin
            s = sel[o*NP +: NP];
            if ($countones(s) == 1) begin
                for (int i = 0; i < NP; i++)
                    if (s[i] && in_valid[i] && rdy[i]) exp_q[o].push_back(in_data[i*DW +: DW]);
            end else if ($countones(s) > 1 && |(s & in_valid)) begin
                hit = 1'b1;
            end
        end
        if (hit && mdl_err != 8'hFF) mdl_err = mdl_err + 8'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [NP-1:0] s;
        logic [NP*NP-1:0] rs;
        rst = 1'b0;
        drive(9'b100_010_001, 24'h332211, 3'b111, 3'b111);
        @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_valid", out_valid, 3'b000);
        check("rst_data", out_data, 24'h0);
        check("rst_err", err_cnt, 8'd0);
        check("rst_ready", in_ready, 3'b000);
        @(negedge clk);
        rst = 1'b1;

        // identity routing
        drive(9'b100_010_001, 24'h332211, 3'b111, 3'b111);
        #1 check("id_ready", in_ready, 3'b111);
        step();
        check("id_data", out_data, 24'h332211);
        check("id_valid", out_valid, 3'b111);

        // multicast blocked by a stalled destination, then released
        drive(9'b010_000_010, 24'h00A500, 3'b010, 3'b011);
        step();
        check("mc_block_valid", out_valid, 3'b100);
        check("mc_block_hold", out_data[23:16], 8'h33);
        drive(9'b010_000_010, 24'h00A500, 3'b010, 3'b111);
        step();
        check("mc_out0", out_data[7:0], 8'hA5);
        check("mc_out2", out_data[23:16], 8'hA5);
        check("mc_valid", out_valid, 3'b101);
        drive(9'b000_000_000, 24'h0, 3'b000, 3'b111);
        step();

        // backpressure hold then full-throughput replace
        drive(9'b000_000_001, 24'h00005A, 3'b001, 3'b111);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(9'b000_000_001, 24'h000077, 3'b001, 3'b110);
            step();
            check("hold_data", out_data[7:0], 8'h5A);
            check("hold_valid", out_valid[0], 1'b1);
        end
        drive(9'b000_000_001, 24'h00006B, 3'b001, 3'b111);
        step();
        check("repl_data", out_data[7:0], 8'h6B);
        check("repl_valid", out_valid[0], 1'b1);
        drive(9'b000_000_000, 24'h0, 3'b000, 3'b111);
        step();

        // illegal multi-hot select: never loads, counter saturates
        for (int k = 0; k < 300; k++) begin
            drive(9'b000_011_000, {16'h0, 8'($urandom)}, 3'b001, 3'b111);
            step();
        end
`ifdef XBAR_PARAM_ERRCNT_EN
        check("err_sat", err_cnt, 8'd255);
`else
        check("err_off", err_cnt, 8'd0);
`endif
        check("illegal_noload", out_valid[1], 1'b0);
        drive(9'b000_000_000, 24'h0, 3'b111, 3'b111);
        step();

        // random traffic, mostly legal selects
        for (int k = 0; k < 200; k++) begin
            for (int o = 0; o < NP; o++) begin
                case ($urandom_range(0, 9))
                    0:       s = 3'b000;
                    1:       s = 3'($urandom_range(3, 7)) | 3'b011;
                    default: s = 3'b001 << $urandom_range(0, 2);
                endcase
                rs[o*NP +: NP] = s;
            end
            drive(rs, 24'($urandom), 3'($urandom), 3'($urandom));
            step();
        end

        // async reset mid-cycle with all outputs full
        drive(9'b100_010_001, 24'hC3B2A1, 3'b111, 3'b111);
        step();
        drive(9'b100_010_001, 24'h0, 3'b000, 3'b000);
        step();
        check("pre_rst_valid", out_valid, 3'b111);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 3'b000);
        check("arst_data", out_data, 24'h0);
        check("arst_err", err_cnt, 8'd0);
        check("arst_ready", in_ready, 3'b000);
        for (int o = 0; o < NP; o++) exp_q[o].delete();
        mdl_err = 8'd0;
        @(negedge clk);
        rst = 1'b1;
        drive(9'b100_010_001, 24'h665544, 3'b111, 3'b111);
        step();
        check("post_rst_data", out_data, 24'h665544);
        check("post_rst_valid", out_valid, 3'b111);
        drive(9'b000_000_000, 24'h0, 3'b000, 3'b111);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
